// File: rtl/fir_decimator_fifo.sv
// Keeps one of every DECIM_FACTOR FIR output strobes and buffers the kept
// samples in a show-ahead FIFO drained over a valid/ack handshake.
module fir_decimator_fifo #(
    parameter int DATA_BITS    = 17,
    parameter int DECIM_FACTOR = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int COUNT_BITS   = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_in_ready,
    input  logic [DATA_BITS-1:0]  data_in,
    output logic                  data_out_valid,
    output logic [DATA_BITS-1:0]  data_out,
    input  logic                  data_out_ack,
    input  logic                  clear_overflow,
    output logic                  overflow,
    output logic [COUNT_BITS-1:0] fifo_count
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PW   = AW + 1;
    localparam int PH_W = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;
    localparam logic [PH_W-1:0]       PH_LAST = PH_W'(DECIM_FACTOR - 1);
    localparam logic [COUNT_BITS-1:0] CNT_ONE = COUNT_BITS'(1);

    logic [PH_W-1:0]      r_phase;
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic [COUNT_BITS-1:0] r_count;
    logic [DATA_BITS-1:0] r_dout;
    logic                 r_ovf;

    logic                 w_kept;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_head_from_input;
    logic [PW-1:0]        w_rptr_nxt;
    logic [DATA_BITS-1:0] w_head_nxt;

    // Pointers carry a wrap bit; with a power-of-2 depth the natural binary
    // wrap of the extra bit gives modulo-depth addressing for free.
    function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
        return p + PW'(1);
    endfunction

    function automatic logic [PH_W-1:0] f_phase_next(input logic [PH_W-1:0] ph);
        return (ph == PH_LAST) ? '0 : ph + PH_W'(1);
    endfunction

    assign w_kept  = data_in_ready && (r_phase == '0);
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_pop   = !w_empty && data_out_ack;
    assign w_push  = w_kept && (!w_full || w_pop);
    assign w_drop  = w_kept && w_full && !w_pop;

    assign w_rptr_nxt = w_pop ? f_ptr_inc(r_rptr) : r_rptr;

    // When the FIFO is (or is about to become) empty, the next head can only be
    // the sample arriving this cycle, which is not yet in the memory array.
    assign w_head_from_input = w_empty || (w_pop && (r_count == CNT_ONE));

    always_comb begin
        w_head_nxt = r_dout;
        if (w_head_from_input) begin
            if (w_push) begin
                w_head_nxt = data_in;
            end
        end else begin
            w_head_nxt = r_mem[w_rptr_nxt[AW-1:0]];
        end
    end

    // Sample storage: data only, never reset.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wptr[AW-1:0]] <= data_in;
        end
    end

    // Control and registered head-of-FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_dout  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (data_in_ready) begin
                r_phase <= f_phase_next(r_phase);
            end
            if (w_push) begin
                r_wptr <= f_ptr_inc(r_wptr);
            end
            r_rptr <= w_rptr_nxt;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_dout <= w_head_nxt;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clear_overflow) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign data_out_valid = !w_empty;
    assign data_out       = r_dout;
    assign overflow       = r_ovf;
    assign fifo_count     = r_count;

endmodule

// File: tb/tb_fir_decimator_fifo.sv
// Bench for fir_decimator_fifo: one instance decimating by 4, one passing through.
module tb_fir_decimator_fifo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        rst4, rdy4, ack4, clr4, vld4, ovf4;
    logic [16:0] din4, dout4;
    logic [3:0]  cnt4;
    logic        rst1, rdy1, ack1, clr1, vld1, ovf1;
    logic [16:0] din1, dout1;
    logic [3:0]  cnt1;

    logic [16:0] exp4[$];
    logic [16:0] exp1[$];

    fir_decimator_fifo #(.DATA_BITS(17), .DECIM_FACTOR(4), .FIFO_DEPTH(8)) u_d4 (
        .clk(clk), .rst(rst4), .data_in_ready(rdy4), .data_in(din4),
        .data_out_valid(vld4), .data_out(dout4), .data_out_ack(ack4),
        .clear_overflow(clr4), .overflow(ovf4), .fifo_count(cnt4));

    fir_decimator_fifo #(.DATA_BITS(17), .DECIM_FACTOR(1), .FIFO_DEPTH(8)) u_d1 (
        .clk(clk), .rst(rst1), .data_in_ready(rdy1), .data_in(din1),
        .data_out_valid(vld1), .data_out(dout1), .data_out_ack(ack1),
        .clear_overflow(clr1), .overflow(ovf1), .fifo_count(cnt1));

    // Scoreboards: every accepted handshake must match the oldest expected sample.
    always @(negedge clk) begin
        if (!rst4 && vld4 && ack4) begin
            n_cmp++;
            if (exp4.size() == 0) begin
                n_bad++;
                $display("FAIL d4_unexpected_output: got %0h, required none", dout4);
            end else begin
                logic [16:0] e;
                e = exp4.pop_front();
                if (dout4 !== e) begin
                    n_bad++;
                    $display("FAIL d4_output_data: got %0h, required %0h", dout4, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst1 && vld1 && ack1) begin
            n_cmp++;
            if (exp1.size() == 0) begin
                n_bad++;
                $display("FAIL d1_unexpected_output: got %0h, required none", dout1);
            end else begin
                logic [16:0] e;
                e = exp1.pop_front();
                if (dout1 !== e) begin
                    n_bad++;
                    $display("FAIL d1_output_data: got %0h, required %0h", dout1, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst4 = 1'b1; rst1 = 1'b1;
        rdy4 = 1'b1; rdy1 = 1'b1; din4 = 17'h1234; din1 = 17'h1234;
        tick();
        tick();
        rst4 = 1'b0; rst1 = 1'b0; rdy4 = 1'b0; rdy1 = 1'b0;
        n_cmp++; if (vld4 !== 1'b0) begin n_bad++; $display("FAIL rst_vld4: got %0b, required 0", vld4); end
        n_cmp++; if (cnt4 !== 4'd0) begin n_bad++; $display("FAIL rst_cnt4: got %0d, required 0", cnt4); end
        n_cmp++; if (ovf4 !== 1'b0) begin n_bad++; $display("FAIL rst_ovf4: got %0b, required 0", ovf4); end
        n_cmp++; if (dout4 !== 17'd0) begin n_bad++; $display("FAIL rst_dout4: got %0h, required 0", dout4); end
        n_cmp++; if (vld1 !== 1'b0) begin n_bad++; $display("FAIL rst_vld1: got %0b, required 0", vld1); end
        n_cmp++; if (cnt1 !== 4'd0) begin n_bad++; $display("FAIL rst_cnt1: got %0d, required 0", cnt1); end
        n_cmp++; if (ovf1 !== 1'b0) begin n_bad++; $display("FAIL rst_ovf1: got %0b, required 0", ovf1); end
        n_cmp++; if (dout1 !== 17'd0) begin n_bad++; $display("FAIL rst_dout1: got %0h, required 0", dout1); end
    endtask

    task automatic test_decimation();
        ack4 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din4 = 17'(i); rdy4 = 1'b1;
            if (i % 4 == 0) exp4.push_back(17'(i));
            tick();
            n_cmp++;
            if (vld4 !== (i % 4 == 0)) begin
                n_bad++;
                $display("FAIL decim_valid_strobe%0d: got %0b, required %0b", i, vld4, (i % 4 == 0));
            end
        end
        rdy4 = 1'b0;
        tick(); tick();
        n_cmp++;
        if (exp4.size() != 0) begin n_bad++; $display("FAIL decim_drain: got %0d left, required 0", exp4.size()); end
    endtask

    task automatic test_passthrough();
        logic [16:0] vals [3];
        vals[0] = 17'h1FFFF; vals[1] = 17'h00001; vals[2] = 17'h10000;
        ack1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din1 = vals[k]; rdy1 = 1'b1; exp1.push_back(vals[k]);
            for (int c = 0; c < 3; c++) begin
                tick();
                rdy1 = 1'b0;
                n_cmp++;
                if (cnt1 > 4'd1) begin n_bad++; $display("FAIL pass_count: got %0d, required <=1", cnt1); end
            end
        end
        n_cmp++;
        if (exp1.size() != 0) begin n_bad++; $display("FAIL pass_drain: got %0d left, required 0", exp1.size()); end
    endtask

    task automatic test_overflow();
        ack1 = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            din1 = 17'(j); rdy1 = 1'b1;
            if (j <= 8) exp1.push_back(17'(j));
            tick();
            n_cmp++;
            if (cnt1 !== 4'((j < 8) ? j : 8)) begin
                n_bad++; $display("FAIL ovf_count_strobe%0d: got %0d, required %0d", j, cnt1, (j < 8) ? j : 8);
            end
            n_cmp++;
            if (ovf1 !== (j >= 9)) begin
                n_bad++; $display("FAIL ovf_flag_strobe%0d: got %0b, required %0b", j, ovf1, (j >= 9));
            end
        end
        rdy1 = 1'b0; ack1 = 1'b1;
        for (int c = 0; c < 20 && exp1.size() != 0; c++) tick();
        tick();
        n_cmp++;
        if (exp1.size() != 0) begin n_bad++; $display("FAIL ovf_drain_timeout: got %0d left, required 0", exp1.size()); end
        n_cmp++;
        if (cnt1 !== 4'd0) begin n_bad++; $display("FAIL ovf_drained_count: got %0d, required 0", cnt1); end
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        n_cmp++;
        if (ovf1 !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %0b, required 0", ovf1); end
    endtask

    task automatic test_full_pushpop();
        ack1 = 1'b0;
        for (int j = 0; j < 8; j++) begin
            din1 = 17'(11 + j); rdy1 = 1'b1; exp1.push_back(17'(11 + j));
            tick();
        end
        din1 = 17'd99; rdy1 = 1'b1; ack1 = 1'b1; exp1.push_back(17'd99);
        tick();
        rdy1 = 1'b0; ack1 = 1'b0;
        n_cmp++;
        if (ovf1 !== 1'b0) begin n_bad++; $display("FAIL full_pp_ovf: got %0b, required 0", ovf1); end
        n_cmp++;
        if (cnt1 !== 4'd8) begin n_bad++; $display("FAIL full_pp_count: got %0d, required 8", cnt1); end
        ack1 = 1'b1;
        for (int c = 0; c < 20 && exp1.size() != 0; c++) tick();
        tick();
        n_cmp++;
        if (exp1.size() != 0) begin n_bad++; $display("FAIL full_pp_drain_timeout: got %0d left, required 0", exp1.size()); end
    endtask

    task automatic test_reset_mid();
        ack4 = 1'b0;
        for (int i = 0; i < 18; i++) begin
            din4 = 17'(100 + i); rdy4 = 1'b1;
            tick();
        end
        n_cmp++;
        if (cnt4 !== 4'd5) begin n_bad++; $display("FAIL rmid_precount: got %0d, required 5", cnt4); end
        rst4 = 1'b1; din4 = 17'd123; rdy4 = 1'b1;
        tick();
        rst4 = 1'b0;
        n_cmp++;
        if (vld4 !== 1'b0) begin n_bad++; $display("FAIL rmid_vld: got %0b, required 0", vld4); end
        n_cmp++;
        if (cnt4 !== 4'd0) begin n_bad++; $display("FAIL rmid_count: got %0d, required 0", cnt4); end
        ack4 = 1'b1;
        for (int v = 7; v <= 11; v++) begin
            din4 = 17'(v); rdy4 = 1'b1;
            if (v == 7 || v == 11) exp4.push_back(17'(v));
            tick();
            if (v == 7) begin
                n_cmp++;
                if (vld4 !== 1'b1 || dout4 !== 17'd7) begin
                    n_bad++; $display("FAIL rmid_first: got vld=%0b data=%0d, required vld=1 data=7", vld4, dout4);
                end
            end
        end
        rdy4 = 1'b0;
        tick(); tick();
        n_cmp++;
        if (exp4.size() != 0) begin n_bad++; $display("FAIL rmid_drain: got %0d left, required 0", exp4.size()); end
    endtask

    task automatic test_ack_empty_and_priority();
        ack1 = 1'b1; rdy1 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (cnt1 !== 4'd0 || vld1 !== 1'b0) begin
                n_bad++; $display("FAIL ack_empty: got cnt=%0d vld=%0b, required cnt=0 vld=0", cnt1, vld1);
            end
        end
        din1 = 17'd55; rdy1 = 1'b1; exp1.push_back(17'd55);
        tick();
        rdy1 = 1'b0;
        n_cmp++;
        if (vld1 !== 1'b1 || dout1 !== 17'd55) begin
            n_bad++; $display("FAIL ack_empty_next_push: got vld=%0b data=%0d, required vld=1 data=55", vld1, dout1);
        end
        tick();
        ack1 = 1'b0;
        for (int j = 0; j < 8; j++) begin
            din1 = 17'(201 + j); rdy1 = 1'b1; exp1.push_back(17'(201 + j));
            tick();
        end
        din1 = 17'd209; rdy1 = 1'b1; clr1 = 1'b1;
        tick();
        rdy1 = 1'b0; clr1 = 1'b0;
        n_cmp++;
        if (ovf1 !== 1'b1) begin n_bad++; $display("FAIL ovf_set_priority: got %0b, required 1", ovf1); end
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        n_cmp++;
        if (ovf1 !== 1'b0) begin n_bad++; $display("FAIL ovf_clear_after_priority: got %0b, required 0", ovf1); end
        ack1 = 1'b1;
        for (int c = 0; c < 20 && exp1.size() != 0; c++) tick();
        tick();
        n_cmp++;
        if (exp1.size() != 0) begin n_bad++; $display("FAIL prio_drain_timeout: got %0d left, required 0", exp1.size()); end
    endtask

    initial begin
        rst4 = 1'b1; rdy4 = 1'b0; ack4 = 1'b0; clr4 = 1'b0; din4 = '0;
        rst1 = 1'b1; rdy1 = 1'b0; ack1 = 1'b0; clr1 = 1'b0; din1 = '0;
        test_reset();
        test_decimation();
        test_passthrough();
        test_overflow();
        test_full_pushpop();
        test_reset_mid();
        test_ack_empty_and_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
